// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// rr_pick is the round-robin priority encoder behind the requester arbiters.
package uart_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned MAX_REQ   = 8;
   localparam int unsigned PTR_W_MAX = 3;

   typedef enum logic {IDLE, XFER} arb_state_t;

   // Index of the first set bit of valid at or after ptr, wrapping modulo n.
   function automatic logic [PTR_W_MAX-1:0] rr_pick(input logic [MAX_REQ-1:0]   valid,
                                                    input logic [PTR_W_MAX-1:0] ptr,
                                                    input int unsigned          n);
      logic        found;
      int unsigned j;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         j = 32'(ptr) + k;
         if (j >= n) j = j - n;
         if (!found && (k < n) && valid[j[PTR_W_MAX-1:0]]) begin
            rr_pick = j[PTR_W_MAX-1:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first valid requester at or after ptr_i.
module rr_picker
   import uart_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [PW-1:0] ptr_i,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   logic [MAX_REQ-1:0] valid_pad;

   always_comb begin
      valid_pad         = '0;
      valid_pad[N-1:0]  = valid_i;
      idx_o             = PW'(rr_pick(valid_pad, PTR_W_MAX'(ptr_i), N));
      any_o             = |valid_i;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among N_REQ message sources.
// A grant is held until the last byte of a message, or revoked by the stall watchdog.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned IDLE_TIMEOUT = 1024,
   parameter int unsigned TMO_W        = 11
) (
   input  logic                    clk_50mhz,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    tx_valid,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_ready,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    abort
);

   localparam int unsigned      PW       = $clog2(N_REQ);
   localparam logic [PW-1:0]    LAST_IDX = PW'(N_REQ - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);

   arb_state_t       state_q;
   logic [PW-1:0]    owner_q, rr_ptr_q, next_ptr, pick_idx;
   logic [TMO_W-1:0] tmo_q;
   logic [N_REQ-1:0] grant_q;
   logic             busy_q, abort_q, pick_any, owner_valid, owner_last;

   rr_picker #(
      .N  (N_REQ),
      .PW (PW)
   ) u_picker (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // grant_q is zero outside XFER, so masking with it gates the whole datapath.
   always_comb begin
      owner_valid = |(req_valid & grant_q);
      owner_last  = |(req_last & grant_q);
      tx_data     = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant_q[i]) tx_data = req_data[i*DATA_W +: DATA_W];
      end
      tx_valid  = owner_valid;
      req_ready = grant_q & {N_REQ{tx_ready}};
      next_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
   end

   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         tmo_q    <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_any) begin
                  state_q <= XFER;
                  owner_q <= pick_idx;
                  grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  busy_q  <= 1'b1;
                  tmo_q   <= '0;
               end
            end
            XFER: begin
               if (tx_valid && tx_ready && owner_last) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  busy_q   <= 1'b0;
                  rr_ptr_q <= next_ptr;
               end else if (owner_valid) begin
                  tmo_q <= '0;
               end else if (tmo_q == TMO_LAST) begin
                  // IDLE_TIMEOUT-th consecutive idle cycle: revoke, owner must restart.
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  busy_q   <= 1'b0;
                  abort_q  <= 1'b1;
                  rr_ptr_q <= next_ptr;
                  tmo_q    <= '0;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: sources replay queued messages, a monitor checks every TX handshake.
module tb_uart_tx_arbiter;

   localparam int unsigned TMO = 1024;

   logic        clk_50mhz = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [15:0] req_data;
   logic        tx_valid, tx_ready, busy, abort;
   logic [7:0]  tx_data;

   logic [8:0]  src0_q[$], src1_q[$];
   logic [9:0]  expq[$];
   logic        en0 = 1'b1, en1 = 1'b1;
   int          sent0 = 0, stop0 = 0;
   int          checks = 0, errors = 0, abort_seen = 0;

   uart_tx_arbiter #(
      .N_REQ        (2),
      .IDLE_TIMEOUT (TMO),
      .TMO_W        (11)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .grant     (grant),
      .busy      (busy),
      .abort     (abort)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Requester models: pop on handshake, present queue head after each rising edge.
   initial begin : sources
      logic [1:0] hs;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk_50mhz);
         hs = req_valid & req_ready;
         @(posedge clk_50mhz);
         #1;
         if (hs[0] && src0_q.size() != 0) begin
            void'(src0_q.pop_front());
            sent0++;
            if (sent0 == stop0) en0 = 1'b0;
         end
         if (hs[1] && src1_q.size() != 0) void'(src1_q.pop_front());
         req_valid[0]  = en0 && (src0_q.size() != 0);
         req_data[7:0] = (src0_q.size() != 0) ? src0_q[0][7:0] : 8'h00;
         req_last[0]   = (src0_q.size() != 0) && src0_q[0][8];
         req_valid[1]  = en1 && (src1_q.size() != 0);
         req_data[15:8] = (src1_q.size() != 0) ? src1_q[0][7:0] : 8'h00;
         req_last[1]   = (src1_q.size() != 0) && src1_q[0][8];
      end
   end

   initial begin : monitor
      logic [9:0] e;
      forever begin
         @(negedge clk_50mhz);
         if (reset_n) begin
            if (abort) abort_seen++;
            if (tx_valid && tx_ready) begin
               if (expq.size() == 0) begin
                  chk("unexpected_byte", {22'd0, grant, tx_data}, 32'h3ff);
               end else begin
                  e = expq.pop_front();
                  chk("tx_byte_grant", {22'd0, grant, tx_data}, {22'd0, e});
               end
            end
         end
      end
   end

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((expq.size() != 0 || busy) && n < budget) begin
         @(negedge clk_50mhz);
         n++;
      end
      chk(name, 32'(n < budget), 32'd1);
      @(posedge clk_50mhz);
      #2;
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      repeat (3) @(posedge clk_50mhz);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin : main
      int n;
      tx_ready = 1'b1;
      reset_n  = 1'b0;
      repeat (3) @(posedge clk_50mhz);
      #2;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b1;
      @(posedge clk_50mhz);
      #2;

      // Single two-byte message from requester 0.
      src0_q.push_back({1'b0, 8'h41});
      src0_q.push_back({1'b1, 8'h42});
      expq.push_back({2'b01, 8'h41});
      expq.push_back({2'b01, 8'h42});
      @(negedge clk_50mhz);
      @(negedge clk_50mhz);
      chk("t1_grant_not_yet", 32'(grant), 32'd0);
      @(negedge clk_50mhz);
      chk("t1_grant", 32'(grant), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      @(negedge clk_50mhz);
      @(negedge clk_50mhz);
      chk("t1_busy_fall", 32'(busy), 32'd0);
      chk("t1_grant_fall", 32'(grant), 32'd0);
      wait_idle("t1_drain", 20);

      // rr_ptr is now 1: requester 1 wins a simultaneous request.
      src0_q.push_back({1'b1, 8'h10});
      src1_q.push_back({1'b1, 8'h11});
      expq.push_back({2'b10, 8'h11});
      expq.push_back({2'b01, 8'h10});
      wait_idle("t1b_drain", 20);

      reset_pulse();
      @(posedge clk_50mhz);
      #2;
      src0_q.push_back({1'b0, 8'hAA});
      src0_q.push_back({1'b0, 8'h55});
      src0_q.push_back({1'b1, 8'h9D});
      src1_q.push_back({1'b1, 8'h0D});
      expq.push_back({2'b01, 8'hAA});
      expq.push_back({2'b01, 8'h55});
      expq.push_back({2'b01, 8'h9D});
      expq.push_back({2'b10, 8'h0D});
      wait_idle("t2_drain", 30);

      // Fairness: requester 0 keeps messages queued, requester 1 still gets its turn.
      src0_q.push_back({1'b0, 8'hE1});
      src0_q.push_back({1'b1, 8'hE2});
      src0_q.push_back({1'b0, 8'hE3});
      src0_q.push_back({1'b1, 8'hE4});
      src0_q.push_back({1'b1, 8'hE5});
      src1_q.push_back({1'b0, 8'hF1});
      src1_q.push_back({1'b1, 8'hF2});
      expq.push_back({2'b01, 8'hE1});
      expq.push_back({2'b01, 8'hE2});
      expq.push_back({2'b10, 8'hF1});
      expq.push_back({2'b10, 8'hF2});
      expq.push_back({2'b01, 8'hE3});
      expq.push_back({2'b01, 8'hE4});
      expq.push_back({2'b01, 8'hE5});
      wait_idle("t3_drain", 40);

      // TX core stalled for 2000 cycles with the owner valid: no abort.
      tx_ready = 1'b0;
      src1_q.push_back({1'b1, 8'hC3});
      expq.push_back({2'b10, 8'hC3});
      n = 0;
      repeat (2000) begin
         @(negedge clk_50mhz);
         if (grant == 2'b10 && tx_valid) n++;
      end
      chk("t4_hold_cycles", 32'(n), 32'd1998);
      chk("t4_no_abort", 32'(abort_seen), 32'd0);
      @(posedge clk_50mhz);
      #2;
      tx_ready = 1'b1;
      wait_idle("t4_drain", 20);

      // Owner goes quiet after one byte: watchdog revokes, requester 1 served next.
      sent0 = 0;
      stop0 = 1;
      src0_q.push_back({1'b0, 8'h31});
      src0_q.push_back({1'b0, 8'h32});
      src0_q.push_back({1'b1, 8'h33});
      src1_q.push_back({1'b1, 8'h77});
      expq.push_back({2'b01, 8'h31});
      expq.push_back({2'b10, 8'h77});
      n = 0;
      do begin
         @(negedge clk_50mhz);
         n++;
      end while (!(tx_valid && tx_ready && grant == 2'b01) && n < 20);
      chk("t5_first_byte", 32'(n < 20), 32'd1);
      n = 0;
      do begin
         @(negedge clk_50mhz);
         if (!abort) n++;
      end while (!abort && n < 1200);
      chk("t5_stall_cycles", 32'(n), 32'(TMO));
      chk("t5_abort_grant", 32'(grant), 32'd0);
      chk("t5_abort_busy", 32'(busy), 32'd0);
      @(negedge clk_50mhz);
      chk("t5_abort_pulse", 32'(abort), 32'd0);
      chk("t5_next_grant", 32'(grant), 32'd2);
      wait_idle("t5_drain", 20);
      chk("t5_abort_count", 32'(abort_seen), 32'd1);
      src0_q.delete();
      stop0 = 0;
      en0   = 1'b1;
      @(posedge clk_50mhz);
      #2;

      // Move rr_ptr to 1, then reset in the middle of requester 1's message.
      src0_q.push_back({1'b1, 8'h5A});
      expq.push_back({2'b01, 8'h5A});
      wait_idle("t6_pre_drain", 20);
      tx_ready = 1'b0;
      src1_q.push_back({1'b0, 8'hA1});
      src1_q.push_back({1'b1, 8'hA2});
      n = 0;
      do begin
         @(negedge clk_50mhz);
         n++;
      end while (!(grant == 2'b10 && tx_valid) && n < 20);
      chk("t6_granted", 32'(n < 20), 32'd1);
      @(posedge clk_50mhz);
      #2;
      tx_ready = 1'b1;
      reset_n  = 1'b0;
      #1;
      chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
      src1_q.delete();
      repeat (3) @(posedge clk_50mhz);
      #2;
      reset_n = 1'b1;
      src0_q.push_back({1'b1, 8'hB0});
      src1_q.push_back({1'b1, 8'hB1});
      expq.push_back({2'b01, 8'hB0});
      expq.push_back({2'b10, 8'hB1});
      wait_idle("t6_drain", 20);
      chk("final_abort_count", 32'(abort_seen), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
